sa_ob_drain: RTL and testbench

//  Reads finished result rows out of the systolic array output buffer SRAM (1-cycle read latency,

---
 rtl/sa_pkg.sv | 16 +
 rtl/sa_skid_fifo.sv | 48 ++++
 rtl/sa_ob_drain.sv | 124 ++++++++++++
 tb/tb_sa_ob_drain.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and default geometry for the systolic array output-buffer drain
package sa_pkg;

    localparam int SA_WIDTH  = 8;
    localparam int SA_COL    = 4;
    localparam int SA_O_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_e;

    typedef logic [SA_COL-1:0][SA_WIDTH-1:0] ob_row_t;

endpackage

// File: rtl/sa_skid_fifo.sv
// rtl/sa_skid_fifo.sv - 2-entry first-word-fall-through FIFO; count feeds the drain read credit
module sa_skid_fifo
    import sa_pkg::*;
#(
    parameter int DW = SA_COL * SA_WIDTH + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sa_ob_drain.sv
// rtl/sa_ob_drain.sv - drains output-buffer rows to a valid/ready stream; SA_DRAIN_RELU_EN clamps negative lanes
module sa_ob_drain
    import sa_pkg::*;
#(
    parameter int WIDTH  = SA_WIDTH,
    parameter int COL    = SA_COL,
    parameter int O_SIZE = SA_O_SIZE,
    localparam int AW    = $clog2(O_SIZE)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AW:0]          len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ob_mem_cenb_o,
    output logic                 ob_mem_wenb_o,
    output logic [AW-1:0]        ob_mem_addr_o,
    input  logic [COL*WIDTH-1:0] ob_mem_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [COL*WIDTH-1:0] m_data_o,
    output logic                 m_last_o
);

    localparam int DW = COL * WIDTH;
    localparam logic [AW:0] ONE = (AW+1)'(1);

    drain_state_e state_q, state_d;
    logic [AW:0]  len_q;
    logic [AW:0]  rd_addr_q;
    logic         inflight_q;
    logic         inflight_last_q;
    logic [DW-1:0] wr_row;
    logic [DW:0]  head;
    logic [1:0]   fifo_count;
    logic [2:0]   occupancy;
    logic         pop;
    logic         rd_en;

    assign m_valid_o = (fifo_count != 2'd0);
    assign m_data_o  = head[DW-1:0];
    assign m_last_o  = m_valid_o & head[DW];
    assign pop       = m_valid_o & m_ready_i;

    // A slot freed by this cycle's pop already counts as credit, which sustains one row per cycle.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign rd_en     = (state_q == RUN) && (rd_addr_q < len_q) && (occupancy < 3'd2);

    assign ob_mem_cenb_o = ~rd_en;
    assign ob_mem_wenb_o = 1'b1;
    assign ob_mem_addr_o = rd_addr_q[AW-1:0];

`ifdef SA_DRAIN_RELU_EN
    always_comb begin
        wr_row = ob_mem_data_i;
        for (int l = 0; l < COL; l++) begin
            if (ob_mem_data_i[l*WIDTH + WIDTH-1]) begin
                wr_row[l*WIDTH +: WIDTH] = '0;
            end
        end
    end
`else
    assign wr_row = ob_mem_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            len_q           <= '0;
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                len_q     <= len_i;
                rd_addr_q <= '0;
            end else if (rd_en) begin
                rd_addr_q <= rd_addr_q + ONE;
            end
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && (rd_addr_q == len_q - ONE);
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (pop && m_last_o) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (!start_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data lands one cycle after cenb; capture it exactly then, tagged with its last flag.
    sa_skid_fifo #(.DW(DW + 1)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, wr_row}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_sa_ob_drain.sv
// tb/tb_sa_ob_drain.sv - randomized self-checking bench for sa_ob_drain with a row-queue reference model
module tb_sa_ob_drain;

    localparam int WIDTH  = 8;
    localparam int COL    = 4;
    localparam int O_SIZE = 64;
    localparam int AW     = 6;

`ifdef SA_DRAIN_RELU_EN
    localparam logic [31:0] EXP_T6 = 32'h7F01_0000;
`else
    localparam logic [31:0] EXP_T6 = 32'h7F01_FF80;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [AW:0] len_i;
    logic        busy_o, done_o;
    logic        ob_mem_cenb_o, ob_mem_wenb_o;
    logic [AW-1:0] ob_mem_addr_o;
    logic [31:0] ob_mem_data_i;
    logic        m_valid_o, m_ready_i, m_last_o;
    logic [31:0] m_data_o;

    logic [31:0] mem [O_SIZE];
    logic [32:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int start_cyc, first_valid_cyc, done_cyc;
    int rd_issued, beats, next_addr, cur_len;
    int ready_mode;
    bit mon_en = 1'b0;
    logic        prev_valid, prev_ready, prev_last;
    logic [31:0] prev_data, last_beat_data;

    sa_ob_drain #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .len_i         (len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .ob_mem_cenb_o (ob_mem_cenb_o),
        .ob_mem_wenb_o (ob_mem_wenb_o),
        .ob_mem_addr_o (ob_mem_addr_o),
        .ob_mem_data_i (ob_mem_data_i),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_data_o      (m_data_o),
        .m_last_o      (m_last_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!ob_mem_cenb_o) ob_mem_data_i <= mem[ob_mem_addr_o];
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] relu_ref(input logic [31:0] r);
        logic [31:0] o;
        o = r;
`ifdef SA_DRAIN_RELU_EN
        for (int l = 0; l < COL; l++) begin
            if ($signed(r[8*l +: 8]) < 0) o[8*l +: 8] = 8'h00;
        end
`endif
        return o;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (!ob_mem_cenb_o) begin
                check_val("rd_addr_order", ob_mem_addr_o, next_addr[AW-1:0]);
                check_val("rd_addr_in_range", next_addr < cur_len, 1);
                check_val("wenb_high", ob_mem_wenb_o, 1);
                next_addr++;
                rd_issued++;
            end
            if (prev_valid && !prev_ready) begin
                check_val("valid_held", m_valid_o, 1);
                check_val("data_stable", m_data_o, prev_data);
                check_val("last_stable", m_last_o, prev_last);
            end
            if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 1, 0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check_val("beat_data", m_data_o, e[31:0]);
                    check_val("beat_last", m_last_o, e[32]);
                end
                last_beat_data = m_data_o;
                beats++;
            end
            check_val("outstanding_le2", (rd_issued - beats) <= 2, 1);
            if (done_o && done_cyc < 0) done_cyc = cyc;
            prev_valid = m_valid_o;
            prev_ready = m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready();
        case (ready_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = ~m_ready_i;
            default: m_ready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic arm_model(input int len);
        exp_q.delete();
        for (int a = 0; a < len; a++) exp_q.push_back({(a == len - 1), relu_ref(mem[a])});
        rd_issued = 0; beats = 0; next_addr = 0; cur_len = len;
        first_valid_cyc = -1; done_cyc = -1;
        prev_valid = 1'b0; prev_ready = 1'b0;
    endtask

    task automatic run_drain(input int len, input int mode);
        bit seen;
        ready_mode = mode;
        arm_model(len);
        m_ready_i = 1'b1;
        start_i = 1'b1;
        len_i = (AW+1)'(len);
        start_cyc = cyc;
        mon_en = 1'b1;
        seen = 1'b0;
        step();
        check_val("busy_after_start", busy_o, len != 0);
        set_ready();
        for (int n = 0; n < 4 * len + 20; n++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            step();
            set_ready();
        end
        check_val("done_reached", seen, 1);
        check_val("beat_count", beats, len);
        check_val("read_count", rd_issued, len);
        check_val("model_drained", exp_q.size(), 0);
        step();
        check_val("done_held_start_high", done_o, 1);
        check_val("no_restart_busy", busy_o, 0);
        start_i = 1'b0;
        step();
        step();
        check_val("done_clear", done_o, 0);
        check_val("idle_busy", busy_o, 0);
        check_val("no_stray_reads", rd_issued, len);
        mon_en = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; len_i = '0; m_ready_i = 1'b0; ready_mode = 0;
        for (int a = 0; a < O_SIZE; a++) mem[a] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_val("rst_cenb", ob_mem_cenb_o, 1);
        check_val("rst_wenb", ob_mem_wenb_o, 1);
        check_val("rst_valid", m_valid_o, 0);
        check_val("rst_last", m_last_o, 0);
        check_val("rst_data", m_data_o, 0);
        check_val("rst_addr", ob_mem_addr_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_done", done_o, 0);

        // T1: row index as data, ready held high
        for (int a = 0; a < O_SIZE; a++) mem[a] = a;
        run_drain(4, 0);
        check_val("t1_first_valid_latency", first_valid_cyc - start_cyc, 3);
        check_val("t1_done_latency", done_cyc - start_cyc, 7);

        // T2: ready toggling
        for (int a = 0; a < O_SIZE; a++) mem[a] = $urandom;
        run_drain(8, 1);

        // T3: empty drain
        run_drain(0, 0);
        check_val("t3_done_latency", done_cyc - start_cyc, 1);
        check_val("t3_no_valid", first_valid_cyc, -1);

        // T4: full buffer
        run_drain(O_SIZE, 0);
        check_val("t4_done_latency", done_cyc - start_cyc, O_SIZE + 3);
        check_val("t4_final_addr", next_addr, O_SIZE);

        // T5: reset mid-drain, then a clean drain from address 0
        ready_mode = 0;
        arm_model(8);
        m_ready_i = 1'b1; start_i = 1'b1; len_i = 7'd8; mon_en = 1'b1;
        for (int n = 0; n < 40 && beats < 3; n++) step();
        check_val("t5_three_beats", beats >= 3, 1);
        mon_en = 1'b0;
        rst_i = 1'b1; start_i = 1'b0;
        step();
        rst_i = 1'b0;
        check_val("t5_valid", m_valid_o, 0);
        check_val("t5_done", done_o, 0);
        check_val("t5_busy", busy_o, 0);
        check_val("t5_cenb", ob_mem_cenb_o, 1);
        step();
        check_val("t5_valid_after", m_valid_o, 0);
        run_drain(8, 2);

        // T6: signed lanes
        mem[0] = 32'h7F01_FF80;
        run_drain(1, 0);
        check_val("t6_relu_row", last_beat_data, EXP_T6);

        // random lengths, contents and backpressure
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < O_SIZE; a++) mem[a] = $urandom;
            run_drain($urandom_range(1, O_SIZE), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
